// File: rtl/logistic_sweep_snd.sv
// logistic_sweep_snd: logistic-map chaos voice.
// x iterates every clock as x' = r*x*(1-x) in FRAC-bit fixed point while r is swept
// (saw, ping-pong), held, or loaded manually. Each clock one oscillator in a bank of
// N_OSC square-wave oscillators gets a new frequency derived from the current x. Their
// outputs are mixed into a 1-bit PWM stream by a first-order sigma-delta modulator.
//
// Ports:
//   clk     in   system clock; all state updates on its rising edge
//   reset   in   synchronous, active-high reset
//   mode    in   r sweep mode: 0 saw, 1 ping-pong, 2 hold, 3 manual
//   r_in    in   manual r value, 2.FRAC fixed point
//   r_load  in   manual load strobe, honoured in mode 3 only
//   snd     out  sigma-delta audio bit
//   r_out   out  current r (2.FRAC)
//   x_out   out  current x (0.FRAC)
module logistic_sweep_snd #(
    parameter int unsigned N_OSC      = 4,
    parameter int unsigned FRAC       = 8,
    parameter int unsigned FREQ       = 25_200_000,
    parameter int unsigned LO_F       = 200,
    parameter int unsigned HI_F       = 1200,
    parameter int unsigned PHASE_BITS = 12,
    parameter int unsigned R_DWELL    = 30_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      mode,
    input  logic [FRAC+1:0] r_in,
    input  logic            r_load,
    output logic            snd,
    output logic [FRAC+1:0] r_out,
    output logic [FRAC-1:0] x_out
);

    localparam int unsigned RW = FRAC + 2;
    localparam int unsigned PW = 3 * FRAC + 3;
    localparam int unsigned XW = FRAC + 3;
    localparam int unsigned IW = PHASE_BITS + FRAC;
    localparam int unsigned DW = $clog2(R_DWELL);
    localparam int unsigned RRW = (N_OSC > 1) ? $clog2(N_OSC) : 1;
    localparam int unsigned AW = $clog2(2 * N_OSC + 1);

    localparam logic [RW-1:0] R_MIN = RW'(2 ** FRAC + 2 ** (FRAC - 4));
    localparam logic [RW-1:0] R_MAX = {RW{1'b1}};
    localparam logic [FRAC-1:0] X_SEED = FRAC'(2 ** (FRAC - 4));
    localparam logic [XW-1:0] X_SAT = XW'(2 ** FRAC - 1);

    // Phase accumulators advance once per 2^PHASE_DEC clocks.
    localparam int PHASE_DEC_RAW = $clog2(FREQ) - int'(PHASE_BITS);
    localparam int PHASE_DEC = (PHASE_DEC_RAW > 0) ? PHASE_DEC_RAW : 0;
    localparam int DIV_W = (PHASE_DEC > 0) ? PHASE_DEC : 1;

    // Increment for tone f: f * 2^PHASE_BITS / (FREQ / 2^PHASE_DEC).
    localparam longint unsigned LO_INC_L =
        (longint'(LO_F) << (PHASE_BITS + PHASE_DEC)) / longint'(FREQ);
    localparam longint unsigned HI_INC_L =
        (longint'(HI_F) << (PHASE_BITS + PHASE_DEC)) / longint'(FREQ);
    localparam logic [PHASE_BITS-1:0] LO_INC = PHASE_BITS'(LO_INC_L);
    localparam logic [PHASE_BITS-1:0] HI_INC = PHASE_BITS'(HI_INC_L);
    localparam logic [PHASE_BITS-1:0] INC_SPAN = HI_INC - LO_INC;

    logic [RW-1:0]         r_q, r_d, r_base;
    logic [FRAC-1:0]       x_q, x_d;
    logic                  dir_up_q, dir_up_d, step_up;
    logic [DW-1:0]         dwell_q;
    logic                  tick;
    logic [RRW-1:0]        rr_q;
    logic [PHASE_BITS-1:0] freq_q  [N_OSC];
    logic [PHASE_BITS-1:0] phase_q [N_OSC];
    logic [DIV_W-1:0]      div_q;
    logic                  phase_step;
    logic [AW-1:0]         acc_q, acc_d, high_cnt, sum;
    logic                  snd_q, snd_d;

    logic [FRAC:0]         x_cmp;
    logic [PW-1:0]         prod;
    logic [XW-1:0]         x_full;
    logic [IW-1:0]         span_x;
    logic [PHASE_BITS-1:0] inc;

    function automatic logic [RW-1:0] clamp_r(input logic [RW-1:0] v);
        if (v < R_MIN) return R_MIN;
        if (v > R_MAX) return R_MAX;
        return v;
    endfunction

    assign tick       = (dwell_q == DW'(R_DWELL - 1));
    assign phase_step = (PHASE_DEC == 0) || (div_q == {DIV_W{1'b1}});

    // Logistic iteration with full-width product; shift only at the end.
    always_comb begin
        x_cmp  = (FRAC + 1)'(2 ** FRAC) - {1'b0, x_q};
        prod   = PW'(r_q) * PW'(x_q) * PW'(x_cmp);
        x_full = prod[PW-1:2*FRAC];
        x_d    = x_full[FRAC-1:0];
        if (x_full > X_SAT) begin
            x_d = {FRAC{1'b1}};
        end else if (x_full == '0) begin
            // Zero is a fixed point of the map; kick x back off it.
            x_d = X_SEED;
        end
    end

    // Tone increment for the oscillator being refreshed this cycle.
    always_comb begin
        span_x = IW'(INC_SPAN) * IW'(x_q);
        inc    = LO_INC + span_x[IW-1:FRAC];
    end

    // r sweep rules.
    always_comb begin
        r_d      = r_q;
        dir_up_d = dir_up_q;
        r_base   = clamp_r(r_q);
        step_up  = dir_up_q;
        case (mode)
            2'd0: begin
                if (tick) r_d = (r_base == R_MAX) ? R_MIN : r_base + RW'(1);
            end
            2'd1: begin
                if (tick) begin
                    // Turn around if already pinned at an end in the wrong direction.
                    if (r_base == R_MAX) step_up = 1'b0;
                    else if (r_base == R_MIN) step_up = 1'b1;
                    r_d = step_up ? r_base + RW'(1) : r_base - RW'(1);
                    if (r_d == R_MAX) dir_up_d = 1'b0;
                    else if (r_d == R_MIN) dir_up_d = 1'b1;
                    else dir_up_d = step_up;
                end
            end
            2'd2: ;
            default: begin
                if (r_load) r_d = clamp_r(r_in);
            end
        endcase
    end

    // Sigma-delta mixer over the oscillator MSBs.
    always_comb begin
        high_cnt = '0;
        for (int i = 0; i < int'(N_OSC); i++) begin
            high_cnt = high_cnt + AW'(phase_q[i][PHASE_BITS-1]);
        end
        sum = acc_q + high_cnt;
        if (sum >= AW'(N_OSC)) begin
            snd_d = 1'b1;
            acc_d = sum - AW'(N_OSC);
        end else begin
            snd_d = 1'b0;
            acc_d = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q      <= R_MIN;
            x_q      <= X_SEED;
            dir_up_q <= 1'b1;
            dwell_q  <= '0;
            rr_q     <= '0;
            div_q    <= '0;
            acc_q    <= '0;
            snd_q    <= 1'b0;
            for (int i = 0; i < int'(N_OSC); i++) begin
                freq_q[i]  <= LO_INC;
                phase_q[i] <= '0;
            end
        end else begin
            r_q      <= r_d;
            x_q      <= x_d;
            dir_up_q <= dir_up_d;
            dwell_q  <= tick ? '0 : dwell_q + DW'(1);
            rr_q     <= (rr_q == RRW'(N_OSC - 1)) ? '0 : rr_q + RRW'(1);
            div_q    <= div_q + DIV_W'(1);
            acc_q    <= acc_d;
            snd_q    <= snd_d;
            freq_q[rr_q] <= inc;
            if (phase_step) begin
                for (int i = 0; i < int'(N_OSC); i++) begin
                    phase_q[i] <= phase_q[i] + freq_q[i];
                end
            end
        end
    end

    assign snd   = snd_q;
    assign r_out = r_q;
    assign x_out = x_q;

endmodule
